ps2_rx: RTL and testbench

- Receives PS/2-style serial frames on the `ps2_clk`/`ps2_dat` line pair and delivers validated bytes over a valid/ready stream.
- Frame format: start 0, 8 data bits LSB-first, odd parity, stop 1.
- The device drives data while `ps2_clk` is high; data is sampled on the `ps2_clk` falling edge. Line clock is 10–16.7 kHz.
- Sits directly downstream of the line driver. Feeds the keyboard-decode logic through a small FIFO.

---
 rtl/ps2_rx_if.sv | 24 ++
 rtl/ps2_rx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_rx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// Line pair, byte stream and status pulses of the PS/2 receiver.
// Suffixes give direction as seen from the receiver (slave side).
interface ps2_rx_if;
  logic       ps2_clk_i;
  logic       ps2_dat_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       timeout_err_o;
  logic       overflow_o;

  modport master (
    output ps2_clk_i, ps2_dat_i, ready_i,
    input  data_o, valid_o, busy_o, parity_err_o, frame_err_o, timeout_err_o, overflow_o
  );

  modport slave (
    input  ps2_clk_i, ps2_dat_i, ready_i,
    output data_o, valid_o, busy_o, parity_err_o, frame_err_o, timeout_err_o, overflow_o
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronise and deglitch the line clock, deserialise
// start/8 data/odd parity/stop frames, and buffer good bytes in a small FIFO.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int FIFO_DEPTH     = 4
) (
  input logic     clk,
  input logic     reset,
  ps2_rx_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WW = $clog2(FILTER_LEN + 3);
  localparam logic [TW-1:0] TOUT     = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TCNT_ONE = TW'(1);
  localparam logic [WW-1:0] WARM     = WW'(FILTER_LEN + 2);
  localparam logic [WW-1:0] WARM_ONE = WW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0]            clk_sync_q;
  logic [1:0]            dat_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;
  logic                  filt_d;
  logic [WW-1:0]         warm_q;
  logic                  armed_q;
  logic                  all_hi_s;
  logic                  all_lo_s;
  logic                  sample_s;
  logic                  bit_s;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  tout_hit_s;
  logic                  push_q, push_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  terr_q, terr_d;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic                  ovf_q;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  wr_en_s;

  assign all_hi_s = &hist_q;
  assign all_lo_s = ~|hist_q;
  assign filt_d   = all_hi_s ? 1'b1 : (all_lo_s ? 1'b0 : filt_q);
  // Edges only count once the line has been seen high with real samples after reset.
  assign sample_s = filt_q & all_lo_s & armed_q;
  assign bit_s    = dat_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      hist_q     <= '1;
      filt_q     <= 1'b1;
      warm_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_dat_i};
      hist_q     <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      filt_q     <= filt_d;
      warm_q     <= (warm_q == WARM) ? warm_q : warm_q + WARM_ONE;
      armed_q    <= armed_q | ((warm_q == WARM) & all_hi_s);
    end
  end

  assign tout_hit_s = (state_q != S_IDLE) && (tcnt_q == TOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tout_hit_s) begin
      state_d = S_IDLE;
    end else if (sample_s) begin
      case (state_q)
        S_IDLE:   state_d = bit_s ? S_IDLE : S_DATA;
        S_DATA:   state_d = (bit_cnt_q == 3'd7) ? S_PARITY : S_DATA;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    push_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    terr_d    = 1'b0;
    if (state_q == S_IDLE || sample_s) begin
      tcnt_d = '0;
    end else if (tcnt_q != TOUT) begin
      tcnt_d = tcnt_q + TCNT_ONE;
    end else begin
      tcnt_d = tcnt_q;
    end
    if (tout_hit_s) begin
      terr_d = 1'b1;
    end else if (sample_s) begin
      case (state_q)
        S_IDLE:   bit_cnt_d = 3'd0;
        S_DATA: begin
          shreg_d[bit_cnt_q] = bit_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
        S_PARITY: par_d = bit_s;
        S_STOP: begin
          // A bad stop bit masks any parity result.
          if (!bit_s) begin
            ferr_d = 1'b1;
          end else if (^{shreg_q, par_q}) begin
            push_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default:  bit_cnt_d = 3'd0;
      endcase
    end else begin
      terr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
      push_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tcnt_q    <= tcnt_d;
      push_q    <= push_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
    end
  end

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = ~empty_s & bus.ready_i;
  assign wr_en_s = push_q & (~full_s | pop_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      ovf_q <= push_q & full_s & ~pop_s;
    end
  end

  assign bus.data_o        = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.valid_o       = ~empty_s;
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.parity_err_o  = perr_q;
  assign bus.frame_err_o   = ferr_q;
  assign bus.timeout_err_o = terr_q;
  assign bus.overflow_o    = ovf_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames on the line pair and compares
// the byte stream and status pulses against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int DEPTH = 4;
  localparam int P10   = 100000;
  localparam int P16   = 60000;

  logic clk = 1'b0;
  logic reset;

  ps2_rx_if bus();

  ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #500 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] dlog[$];
  int exp_perr = 0, exp_ferr = 0, exp_terr = 0, exp_ovf = 0;
  int n_perr = 0, n_ferr = 0, n_terr = 0, n_ovf = 0, vcyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Frame-level outcome: what a finished frame must produce.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) exp_ferr++;
    else if ((^{d, par}) == 1'b0) exp_perr++;
    else if (mq.size() >= DEPTH) exp_ovf++;
    else mq.push_back(d);
  endtask

  task automatic line_bit(input logic b, input int p);
    #(p/4) bus.ps2_dat_i = b;
    #(p/4) bus.ps2_clk_i = 1'b0;
  endtask

  task automatic line_rise(input int p);
    #(p/2) bus.ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int p);
    logic [10:0] frm;
    frm = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      line_bit(frm[i], p);
      if (i == 10) model_frame(d, par, stop);
      line_rise(p);
    end
    #(p/4) bus.ps2_dat_i = 1'b1;
    #(p);
  endtask

  task automatic send_good(input logic [7:0] d, input int p);
    send_frame(d, ~^d, 1'b1, p);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits, input int p);
    logic [8:0] frm;
    frm = {d, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      line_bit(frm[i], p);
      line_rise(p);
    end
    #(p/4) bus.ps2_dat_i = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"},  int'(bus.data_o), 0);
    chk({tag, "_valid"}, int'(bus.valid_o), 0);
    chk({tag, "_busy"},  int'(bus.busy_o), 0);
    chk({tag, "_perr"},  int'(bus.parity_err_o), 0);
    chk({tag, "_ferr"},  int'(bus.frame_err_o), 0);
    chk({tag, "_terr"},  int'(bus.timeout_err_o), 0);
    chk({tag, "_ovf"},   int'(bus.overflow_o), 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_perr_cnt"}, n_perr, exp_perr);
    chk({tag, "_ferr_cnt"}, n_ferr, exp_ferr);
    chk({tag, "_terr_cnt"}, n_terr, exp_terr);
    chk({tag, "_ovf_cnt"},  n_ovf,  exp_ovf);
    chk({tag, "_pending"},  mq.size(), 0);
  endtask

  // Compare process: pulse counting, stream ordering and hold-while-stalled.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic [7:0] exp_b;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (bus.parity_err_o)  n_perr++;
        if (bus.frame_err_o)   n_ferr++;
        if (bus.timeout_err_o) n_terr++;
        if (bus.overflow_o)    n_ovf++;
        if (bus.valid_o)       vcyc++;
        if (prev_hold) begin
          checks++;
          if (bus.valid_o !== 1'b1 || bus.data_o !== prev_data) begin
            errors++;
            $display("FAIL hold: valid=%b data=0x%0h expected valid=1 data=0x%0h",
                     bus.valid_o, bus.data_o, prev_data);
          end
        end
        if (bus.valid_o && bus.ready_i) begin
          checks++;
          if (mq.size() == 0) begin
            errors++;
            $display("FAIL stream: got unexpected byte 0x%0h expected none", bus.data_o);
          end else begin
            exp_b = mq.pop_front();
            if (bus.data_o !== exp_b) begin
              errors++;
              $display("FAIL stream: got 0x%0h expected 0x%0h", bus.data_o, exp_b);
            end
          end
          dlog.push_back(bus.data_o);
        end
        prev_hold = bus.valid_o & ~bus.ready_i;
        prev_data = bus.data_o;
      end
    end
  end

  initial begin
    int t_before;
    bus.ps2_clk_i = 1'b1;
    bus.ps2_dat_i = 1'b1;
    bus.ready_i   = 1'b1;
    reset         = 1'b1;
    #2300;
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);

    // Good bytes at both line-rate extremes.
    send_good(8'hA5, P10);
    send_good(8'h01, P16);
    check_model("good");
    chk("good_log_size", dlog.size(), 2);
    chk("good_byte0", int'(dlog[0]), 8'hA5);
    chk("good_byte1", int'(dlog[1]), 8'h01);
    chk("good_valid_cycles", vcyc, 2);

    send_frame(8'h3C, 1'b0, 1'b1, P16);
    check_model("parity");
    chk("parity_pulse_literal", n_perr, 1);
    chk("parity_no_valid", vcyc, 2);

    send_frame(8'hFF, 1'b1, 1'b0, P16);
    send_good(8'h12, P16);
    check_model("frame");
    chk("frame_pulse_literal", n_ferr, 1);
    chk("frame_next_byte", int'(dlog[2]), 8'h12);

    send_partial(8'h0B, 4, P16);
    repeat (10) @(posedge clk);
    chk("timeout_busy_mid", int'(bus.busy_o), 1);
    exp_terr++;
    #300000;
    chk("timeout_busy_after", int'(bus.busy_o), 0);
    chk("timeout_pulse_literal", n_terr, 1);
    send_good(8'h55, P16);
    check_model("timeout");
    chk("timeout_next_byte", int'(dlog[3]), 8'h55);

    // Overflow with the consumer stalled.
    @(posedge clk); #1 bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send_good(8'h10 + 8'(i), P16);
    chk("ovf_valid_stalled", int'(bus.valid_o), 1);
    chk("ovf_head_stalled", int'(bus.data_o), 8'h10);
    chk("ovf_pulse_literal", n_ovf, 1);
    @(posedge clk); #1 bus.ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_valid_drained", int'(bus.valid_o), 0);
    check_model("ovf");
    for (int i = 0; i < 4; i++) chk("ovf_order", int'(dlog[4 + i]), 8'h10 + i);
    chk("ovf_log_size", dlog.size(), 8);

    // Short low glitch with data low must not look like a start bit.
    @(posedge clk); #1 bus.ps2_dat_i = 1'b0;
    bus.ps2_clk_i = 1'b0;
    @(posedge clk); @(posedge clk); #1 bus.ps2_clk_i = 1'b1;
    bus.ps2_dat_i = 1'b1;
    repeat (20) @(posedge clk);
    chk("glitch_busy", int'(bus.busy_o), 0);

    // Reset in the middle of a frame.
    send_partial(8'h7E, 3, P16);
    repeat (5) @(posedge clk);
    chk("rst_mid_busy", int'(bus.busy_o), 1);
    t_before = n_perr + n_ferr + n_terr + n_ovf;
    @(posedge clk); #1 reset = 1'b1;
    mq.delete();
    #3000;
    check_outputs_zero("rst_mid");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    chk("rst_mid_no_pulse", n_perr + n_ferr + n_terr + n_ovf, t_before);
    send_good(8'h7E, P16);
    check_model("rst_mid");
    chk("rst_mid_byte", int'(dlog[dlog.size() - 1]), 8'h7E);

    // Line clock held low across reset must not yield a sample.
    @(posedge clk); #1 bus.ps2_dat_i = 1'b0;
    bus.ps2_clk_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    chk("low_rst_busy", int'(bus.busy_o), 0);
    #1 bus.ps2_clk_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.ps2_dat_i = 1'b1;
    repeat (20) @(posedge clk);
    chk("low_rst_busy_after", int'(bus.busy_o), 0);
    check_model("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
